load_store_unit: RTL and testbench

Multicycle load/store unit between the core datapath and the unified instruction/data memory port. It accepts one load or store per request from the control FSM and encodes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into a word-aligned, byte-enabled memory transaction. It waits on a ready handshake, with a timeout, and returns sign- or zero-extended load data together with a fault flag. It replaces direct word-only memory access on the data path.

---
 rtl/load_store_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: multicycle RV32I load/store engine in front of the unified
// memory port. It encodes LB/LH/LW/LBU/LHU/SB/SH/SW into a word-aligned,
// byte-enabled bus access, waits for mem_ready with a timeout, and returns
// extended load data plus a fault flag.
//
// Handshakes: the core request is taken on a cycle where req_valid && req_ready
// (req_ready is high only in IDLE). The bus access is held stable while
// mem_valid is high, and it completes on the first cycle where mem_ready is
// sampled high; mem_rdata is valid in that same cycle. rsp_valid is a single
// cycle pulse and rsp_fault/rsp_rdata are meaningful only while it is high.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned halfword
// and word accesses in IDLE without touching the bus.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Counter value of the last BUS cycle that may still see mem_ready.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic        w_illegal;
    logic        w_misalign;
    logic        w_pre_fault;
    logic        w_timeout;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Decode the incoming request for faults that skip the bus entirely.
    always_comb begin
        if (req_write) begin
            w_illegal = (req_funct3 > 3'b010);
        end else begin
            w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        w_pre_fault = w_illegal || w_misalign;
    end

    assign w_timeout = (r_cnt == TO_LAST);
    assign w_off     = r_addr[1:0];

    // Byte-lane encoding of the registered store/load size and offset.
    always_comb begin
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    // Select and extend the addressed lane of the returned read word.
    always_comb begin
        w_shifted = mem_rdata >> {w_off, 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = w_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = mem_rdata;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = w_pre_fault ? S_RESP : S_BUS;
                end
            end
            S_BUS: begin
                if (mem_ready || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture, timeout counting and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr   <= 32'd0;
            r_funct3 <= 3'd0;
            r_write  <= 1'b0;
            r_wdata  <= 32'd0;
            r_cnt    <= 8'd0;
            r_rdata  <= 32'd0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr   <= req_addr;
                        r_funct3 <= req_funct3;
                        r_write  <= req_write;
                        r_wdata  <= req_wdata;
                        r_cnt    <= 8'd0;
                        r_rdata  <= 32'd0;
                        r_fault  <= w_pre_fault;
                    end
                end
                S_BUS: begin
                    // A ready in the timeout cycle still completes cleanly.
                    if (mem_ready) begin
                        r_rdata <= r_write ? 32'd0 : w_load;
                        r_fault <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= 32'd0;
                        r_fault <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the state and the registered request only.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_fault = 1'b0;
        rsp_rdata = 32'd0;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (r_state)
            S_IDLE: req_ready = 1'b1;
            S_BUS: begin
                mem_valid = 1'b1;
                mem_we    = r_write;
                mem_be    = w_be;
                mem_addr  = {r_addr[31:2], 2'b00};
                mem_wdata = w_wdata;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_fault = r_fault;
                rsp_rdata = r_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomized bench for load_store_unit with
// TIMEOUT_CYCLES=4. A byte-level reference model computes lanes, enables and
// extended load data; expected responses flow through a queue.
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // reference model: access size in bytes, starting byte lane
  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic int lane_start(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = acc_size(f3);
    return ((a % 4) / sz) * sz;
  endfunction

  function automatic bit m_fault_pre(input logic w, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (w) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else   legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % acc_size(f3)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned mask;
    mask = (1 << acc_size(f3)) - 1;
    mask = mask << lane_start(f3, a);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (acc_size(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] mask;
    logic [31:0] v;
    int sz;
    sz = acc_size(f3);
    if (sz == 4) return rd;
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    v = (rd >> (8 * lane_start(f3, a))) & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // driver: one complete access; delay = BUS cycle index (0-based) at which
  // mem_ready is raised; delay >= T means the access times out
  task automatic run_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int delay, input logic [31:0] rd);
    bit pre;
    bit timed_out;
    bit got_ready;
    int n;
    logic [31:0] exp_r;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check_val("req_ready_wait", {31'd0, req_ready}, 32'd1);
    pre = m_fault_pre(w, f3, a);
    timed_out = (delay >= T);
    exp_q.push_back((pre || timed_out || w) ? 32'd0 : m_load(f3, a, rd));
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    if (!pre) begin
      n = 0;
      got_ready = 1'b0;
      while (!got_ready && n < T) begin
        check_val("bus_mem_valid", {31'd0, mem_valid}, 32'd1);
        check_val("bus_req_ready", {31'd0, req_ready}, 32'd0);
        check_val("bus_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("bus_we", {31'd0, mem_we}, {31'd0, w});
        check_val("bus_be", {28'd0, mem_be}, {28'd0, m_be(f3, a)});
        check_val("bus_addr", mem_addr, a & 32'hFFFF_FFFC);
        if (w) check_val("bus_wdata", mem_wdata, m_wdata(f3, wd));
        if (n == delay) begin
          mem_ready = 1'b1;
          mem_rdata = rd;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
        @(posedge clk);
        #1;
        if (mem_ready) got_ready = 1'b1;
        else n++;
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    exp_r = exp_q.pop_front();
    check_val("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("rsp_fault", {31'd0, rsp_fault}, {31'd0, (pre || timed_out)});
    check_val("rsp_rdata", rsp_rdata, exp_r);
    check_val("rsp_mem_valid", {31'd0, mem_valid}, 32'd0);
    // a request offered during RESP must be ignored
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    check_val("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("post_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("post_mem_valid", {31'd0, mem_valid}, 32'd0);
    req_valid = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_mem_be", {28'd0, mem_be}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // directed cases
    run_access(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'h0);
    run_access(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 1, 32'h0);
    run_access(1'b1, 3'b001, 32'h0000_0302, 32'h1234_5678, 2, 32'h0);
    run_access(1'b0, 3'b000, 32'h0000_0202, 32'h0, 0, 32'h12F0_3456);
    run_access(1'b0, 3'b100, 32'h0000_0202, 32'h0, 0, 32'h12F0_3456);
    run_access(1'b0, 3'b101, 32'h0000_0202, 32'h0, 0, 32'h12F0_3456);
    run_access(1'b0, 3'b001, 32'h0000_0202, 32'h0, 1, 32'h8001_7FFF);
    run_access(1'b0, 3'b010, 32'h0000_0400, 32'h0, T, 32'hCAFE_F00D);
    run_access(1'b0, 3'b010, 32'h0000_0400, 32'h0, T - 1, 32'hCAFE_F00D);
    run_access(1'b0, 3'b001, 32'h0000_0101, 32'h0, 0, 32'hABCD_9876);
    run_access(1'b0, 3'b010, 32'h0000_0103, 32'h0, 0, 32'h1357_9BDF);
    run_access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);
    run_access(1'b0, 3'b110, 32'h0000_0100, 32'h0, 0, 32'h0);
    run_access(1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 32'h0);

    // reset in the second BUS cycle abandons the access
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0500;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_ready = 1'b0;
    check_val("mr_bus1_valid", {31'd0, mem_valid}, 32'd1);
    @(posedge clk);
    #1;
    check_val("mr_bus2_valid", {31'd0, mem_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("mr_mem_valid", {31'd0, mem_valid}, 32'd0);
    check_val("mr_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val("mr_after_rsp", {31'd0, rsp_valid}, 32'd0);
      check_val("mr_after_mem", {31'd0, mem_valid}, 32'd0);
    end
    run_access(1'b0, 3'b010, 32'h0000_0600, 32'h0, 1, 32'h0BAD_CAFE);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = {22'd0, a[9:0]};
      run_access(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
                 int'($urandom_range(0, T + 1)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
